// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, FSM encodings and the
// byte-lane merge used when committing strobed writes.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam int         ADDR_LSB    = 2;

    typedef enum logic [1:0] {
        WR_IDLE   = 2'b00,
        WR_COMMIT = 2'b01,
        WR_RESP   = 2'b10
    } wr_state_t;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_RESP = 1'b1
    } rd_state_t;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  strb);
        logic [31:0] merged;
        merged = old_word;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) merged[8*b +: 8] = new_word[8*b +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/axi_lite_slave_wr_fsm.sv
// AXI4-Lite write channel: captures AW and W in either order, raises a one-cycle
// commit strobe with the decoded target, then holds the B response until accepted.
module axi_lite_slave_wr_fsm
    import axi_lite_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    NUM_REGS   = 8,
    parameter logic [ADDR_WIDTH-1:0] BASEADDR   = '0,
    parameter int                    IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] awaddr,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [31:0]           wdata,
    input  logic [3:0]            wstrb,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready,
    output logic                  commit,
    output logic [IDX_W-1:0]      commit_idx,
    output logic [31:0]           commit_data,
    output logic [3:0]            commit_strb,
    output logic                  commit_err
);

    localparam logic [ADDR_WIDTH-1:0] NUM_REGS_W = ADDR_WIDTH'(NUM_REGS);

    wr_state_t             state, state_next;
    logic                  aw_done, w_done;
    logic [ADDR_WIDTH-1:0] addr_q, off, word;
    logic [31:0]           data_q;
    logic [3:0]            strb_q;
    logic                  aw_hs, w_hs;

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;

    assign off         = addr_q - BASEADDR;
    assign word        = off >> ADDR_LSB;
    assign commit      = (state == WR_COMMIT);
    assign commit_idx  = word[IDX_W-1:0];
    assign commit_data = data_q;
    assign commit_strb = strb_q;
    assign commit_err  = !((addr_q >= BASEADDR) && (word < NUM_REGS_W));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= WR_IDLE;
        else     state <= state_next;
    end

    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            WR_IDLE:   if ((aw_done || aw_hs) && (w_done || w_hs)) state_next = WR_COMMIT;
            WR_COMMIT: state_next = WR_RESP;
            WR_RESP:   if (bvalid && bready) state_next = WR_IDLE;
            default:   state_next = WR_IDLE;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            awready <= 1'b0;
            wready  <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            bvalid  <= 1'b0;
            bresp   <= RESP_OKAY;
            addr_q  <= '0;
            data_q  <= '0;
            strb_q  <= '0;
        end else begin
            case (state)
                WR_IDLE: begin
                    if (aw_hs) begin
                        addr_q  <= awaddr;
                        aw_done <= 1'b1;
                        awready <= 1'b0;
                    end else if (!aw_done) begin
                        awready <= 1'b1;
                    end
                    if (w_hs) begin
                        data_q <= wdata;
                        strb_q <= wstrb;
                        w_done <= 1'b1;
                        wready <= 1'b0;
                    end else if (!w_done) begin
                        wready <= 1'b1;
                    end
                end
                WR_COMMIT: begin
                    bvalid <= 1'b1;
                    bresp  <= commit_err ? RESP_SLVERR : RESP_OKAY;
                end
                WR_RESP: begin
                    if (bready) begin
                        bvalid  <= 1'b0;
                        awready <= 1'b1;
                        wready  <= 1'b1;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/axi_lite_slave_regbank.sv
// AXI4-Lite slave with C_NUM_REGS read/write control registers exposed on REG_OUT.
// Define AXI_LITE_REGBANK_WRPULSE_EN to add the per-register REG_WR_PULSE output.
module axi_lite_slave_regbank
    import axi_lite_pkg::*;
#(
    parameter int                            C_S_AXI_ADDR_WIDTH = 32,
    parameter int                            C_S_AXI_DATA_WIDTH = 32,
    parameter int                            C_NUM_REGS         = 8,
    parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_BASEADDR         = 32'h0000_0000
) (
    input  logic                          S_AXI_ACLK,
    input  logic                          S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
    input  logic [2:0]                    S_AXI_AWPROT,
    input  logic                          S_AXI_AWVALID,
    output logic                          S_AXI_AWREADY,
    input  logic [31:0]                   S_AXI_WDATA,
    input  logic [3:0]                    S_AXI_WSTRB,
    input  logic                          S_AXI_WVALID,
    output logic                          S_AXI_WREADY,
    output logic [1:0]                    S_AXI_BRESP,
    output logic                          S_AXI_BVALID,
    input  logic                          S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic [2:0]                    S_AXI_ARPROT,
    input  logic                          S_AXI_ARVALID,
    output logic                          S_AXI_ARREADY,
    output logic [31:0]                   S_AXI_RDATA,
    output logic [1:0]                    S_AXI_RRESP,
    output logic                          S_AXI_RVALID,
    input  logic                          S_AXI_RREADY,
    output logic [32*C_NUM_REGS-1:0]      REG_OUT
`ifdef AXI_LITE_REGBANK_WRPULSE_EN
    ,
    output logic [C_NUM_REGS-1:0]         REG_WR_PULSE
`endif
);

    localparam int IDX_W = (C_NUM_REGS > 1) ? $clog2(C_NUM_REGS) : 1;
    localparam logic [C_S_AXI_ADDR_WIDTH-1:0] NUM_REGS_W = C_S_AXI_ADDR_WIDTH'(C_NUM_REGS);

    logic             clk, rst;
    logic [31:0]      regs [C_NUM_REGS];
    logic             wr_commit, wr_err;
    logic [IDX_W-1:0] wr_idx;
    logic [31:0]      wr_data;
    logic [3:0]       wr_strb;
    logic             unused_prot;

    assign clk         = S_AXI_ACLK;
    assign rst         = S_AXI_ARESET;
    assign unused_prot = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, 1'b0};

    axi_lite_slave_wr_fsm #(
        .ADDR_WIDTH (C_S_AXI_ADDR_WIDTH),
        .NUM_REGS   (C_NUM_REGS),
        .BASEADDR   (C_BASEADDR),
        .IDX_W      (IDX_W)
    ) u_wr_fsm (
        .clk         (clk),
        .rst         (rst),
        .awaddr      (S_AXI_AWADDR),
        .awvalid     (S_AXI_AWVALID),
        .awready     (S_AXI_AWREADY),
        .wdata       (S_AXI_WDATA),
        .wstrb       (S_AXI_WSTRB),
        .wvalid      (S_AXI_WVALID),
        .wready      (S_AXI_WREADY),
        .bresp       (S_AXI_BRESP),
        .bvalid      (S_AXI_BVALID),
        .bready      (S_AXI_BREADY),
        .commit      (wr_commit),
        .commit_idx  (wr_idx),
        .commit_data (wr_data),
        .commit_strb (wr_strb),
        .commit_err  (wr_err)
    );

    // NOTE: control registers have defined reset values, so this array is flops with a reset, not a RAM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < C_NUM_REGS; i++) regs[i] <= '0;
        end else if (wr_commit && !wr_err) begin
            regs[wr_idx] <= byte_merge(regs[wr_idx], wr_data, wr_strb);
        end
    end

    always_comb begin
        for (int i = 0; i < C_NUM_REGS; i++) REG_OUT[32*i +: 32] = regs[i];
    end

`ifdef AXI_LITE_REGBANK_WRPULSE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            REG_WR_PULSE <= '0;
        end else begin
            REG_WR_PULSE <= '0;
            if (wr_commit && !wr_err && (|wr_strb)) REG_WR_PULSE[wr_idx] <= 1'b1;
        end
    end
`endif

    // Read path samples regs before any same-edge commit lands.
    rd_state_t                     rd_state, rd_next;
    logic [C_S_AXI_ADDR_WIDTH-1:0] rd_off, rd_word;
    logic [IDX_W-1:0]              rd_idx;
    logic                          rd_in_range, ar_hs;

    assign ar_hs       = S_AXI_ARVALID && S_AXI_ARREADY;
    assign rd_off      = S_AXI_ARADDR - C_BASEADDR;
    assign rd_word     = rd_off >> ADDR_LSB;
    assign rd_idx      = rd_word[IDX_W-1:0];
    assign rd_in_range = (S_AXI_ARADDR >= C_BASEADDR) && (rd_word < NUM_REGS_W);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rd_state <= RD_IDLE;
        else     rd_state <= rd_next;
    end

    always_comb begin
        rd_next = rd_state;
        case (rd_state)
            RD_IDLE: if (ar_hs) rd_next = RD_RESP;
            RD_RESP: if (S_AXI_RREADY) rd_next = RD_IDLE;
            default: rd_next = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RDATA   <= '0;
            S_AXI_RRESP   <= RESP_OKAY;
        end else begin
            case (rd_state)
                RD_IDLE: begin
                    if (ar_hs) begin
                        S_AXI_ARREADY <= 1'b0;
                        S_AXI_RVALID  <= 1'b1;
                        S_AXI_RDATA   <= rd_in_range ? regs[rd_idx] : '0;
                        S_AXI_RRESP   <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
                    end else begin
                        S_AXI_ARREADY <= 1'b1;
                    end
                end
                RD_RESP: begin
                    if (S_AXI_RREADY) begin
                        S_AXI_RVALID  <= 1'b0;
                        S_AXI_ARREADY <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_slave_regbank.sv
// Randomised AXI4-Lite bench for axi_lite_slave_regbank against an array model of the bank.
module tb_axi_lite_slave_regbank;

    localparam int          NR   = 8;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       awaddr, wdata, araddr;
    logic [3:0]        wstrb;
    logic              awvalid, wvalid, bready, arvalid, rready;
    logic              awready, wready, bvalid, arready, rvalid;
    logic [1:0]        bresp, rresp;
    logic [31:0]       rdata;
    logic [32*NR-1:0]  reg_out;
`ifdef AXI_LITE_REGBANK_WRPULSE_EN
    logic [NR-1:0]     wr_pulse;
`endif

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] model [NR];

    always #5 clk = ~clk;

    axi_lite_slave_regbank #(
        .C_S_AXI_ADDR_WIDTH (32),
        .C_S_AXI_DATA_WIDTH (32),
        .C_NUM_REGS         (NR),
        .C_BASEADDR         (BASE)
    ) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESET  (rst),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (3'b000),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (3'b000),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .REG_OUT       (reg_out)
`ifdef AXI_LITE_REGBANK_WRPULSE_EN
        ,
        .REG_WR_PULSE  (wr_pulse)
`endif
    );

    task automatic check(input string tag, input logic [32*NR-1:0] obs, input logic [32*NR-1:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit in_rng(input logic [31:0] a);
        logic [31:0] w;
        w = (a - BASE) >> 2;
        return (a >= BASE) && (w < 32'(NR));
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w, input logic [31:0] new_w,
                                                input logic [3:0] strb);
        logic [31:0] m;
        m = old_w;
        for (int b = 0; b < 4; b++) if (strb[b]) m[8*b +: 8] = new_w[8*b +: 8];
        return m;
    endfunction

    function automatic logic [32*NR-1:0] model_vec();
        logic [32*NR-1:0] v;
        for (int i = 0; i < NR; i++) v[32*i +: 32] = model[i];
        return v;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < NR; i++) model[i] = '0;
    endtask

    // Drive AW and W with independent start delays; returns 1 after the edge of the last handshake.
    task automatic send_aw_w(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly);
        bit aw_ok, w_ok, aw_fire, w_fire;
        int cyc;
        aw_ok = 0; w_ok = 0; cyc = 0;
        while (!(aw_ok && w_ok) && cyc < 64) begin
            awaddr  = addr;
            wdata   = data;
            wstrb   = strb;
            awvalid = !aw_ok && (cyc >= aw_dly);
            wvalid  = !w_ok && (cyc >= w_dly);
            if (aw_ok) check("awready_hold", awready, 0);
            if (w_ok)  check("wready_hold", wready, 0);
            check("bvalid_idle", bvalid, 0);
            aw_fire = awvalid && awready;
            w_fire  = wvalid && wready;
            @(posedge clk); #1;
            aw_ok |= aw_fire;
            w_ok  |= w_fire;
            cyc++;
        end
        awvalid = 0;
        wvalid  = 0;
        check("aw_w_done", aw_ok && w_ok, 1);
    endtask

    task automatic finish_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                                input int b_dly);
        logic [1:0] exp_resp;
`ifdef AXI_LITE_REGBANK_WRPULSE_EN
        logic [NR-1:0] exp_pulse;
        exp_pulse = '0;
`endif
        check("bvalid_early", bvalid, 0);
        @(posedge clk); #1;
        exp_resp = in_rng(addr) ? 2'b00 : 2'b10;
        if (in_rng(addr)) begin
            model[idx_of(addr)] = merge_bytes(model[idx_of(addr)], data, strb);
`ifdef AXI_LITE_REGBANK_WRPULSE_EN
            if (strb != 4'b0000) exp_pulse[idx_of(addr)] = 1'b1;
`endif
        end
        check("bvalid", bvalid, 1);
        check("bresp", bresp, exp_resp);
        check("reg_out", reg_out, model_vec());
`ifdef AXI_LITE_REGBANK_WRPULSE_EN
        check("wr_pulse", wr_pulse, exp_pulse);
`endif
        for (int k = 0; k < b_dly; k++) begin
            @(posedge clk); #1;
            check("bvalid_hold", bvalid, 1);
            check("bresp_hold", bresp, exp_resp);
            check("awready_low", awready, 0);
            check("wready_low", wready, 0);
        end
        bready = 1;
        @(posedge clk); #1;
        bready = 0;
        check("bvalid_clr", bvalid, 0);
        check("awready_back", awready, 1);
        check("wready_back", wready, 1);
`ifdef AXI_LITE_REGBANK_WRPULSE_EN
        check("wr_pulse_clr", wr_pulse, 0);
`endif
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int b_dly);
        send_aw_w(addr, data, strb, aw_dly, w_dly);
        finish_write(addr, data, strb, b_dly);
    endtask

    task automatic do_read(input logic [31:0] addr, input int r_dly);
        int          cyc;
        logic [31:0] exp_d;
        logic [1:0]  exp_r;
        check("rvalid_idle", rvalid, 0);
        araddr  = addr;
        arvalid = 1;
        cyc     = 0;
        while (!arready && cyc < 64) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("arready", arready, 1);
        exp_d = '0;
        exp_r = 2'b10;
        if (in_rng(addr)) begin
            exp_d = model[idx_of(addr)];
            exp_r = 2'b00;
        end
        @(posedge clk); #1;
        arvalid = 0;
        check("rvalid", rvalid, 1);
        check("rdata", rdata, exp_d);
        check("rresp", rresp, exp_r);
        check("arready_low", arready, 0);
        for (int k = 0; k < r_dly; k++) begin
            @(posedge clk); #1;
            check("rvalid_hold", rvalid, 1);
            check("rdata_hold", rdata, exp_d);
        end
        rready = 1;
        @(posedge clk); #1;
        rready = 0;
        check("rvalid_clr", rvalid, 0);
        check("arready_back", arready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a;
        rst = 1; awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        check("rst_awready", awready, 0);
        check("rst_wready", wready, 0);
        check("rst_arready", arready, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_bresp", bresp, 0);
        check("rst_rresp", rresp, 0);
        check("rst_rdata", rdata, 0);
        check("rst_reg_out", reg_out, 0);
        #3 rst = 0;
        @(posedge clk); #1;
        check("ready_after_rst", {awready, wready, arready}, 3'b111);

        // Same-cycle AW/W, then read back
        do_write(BASE + 32'h4, 32'hDEADBEEF, 4'hF, 0, 0, 0);
        check("deadbeef", reg_out[63:32], 32'hDEADBEEF);
        do_read(BASE + 32'h4, 0);

        // W three cycles ahead of AW with a partial strobe
        do_write(BASE + 32'hC, 32'hAABBCCDD, 4'hF, 0, 0, 0);
        do_write(BASE + 32'hC, 32'h11223344, 4'b0101, 3, 0, 0);
        check("merge", reg_out[127:96], 32'hAA22CC44);
        do_read(BASE + 32'hC, 1);

        // Out of range at index NR
        do_write(BASE + 32'h20, 32'h5555_5555, 4'hF, 0, 1, 0);
        do_read(BASE + 32'h20, 1);

        // Backpressured B channel, then an all-zero strobe
        do_write(BASE + 32'h10, 32'h1234_5678, 4'hF, 1, 0, 5);
        do_write(BASE + 32'h10, 32'hFFFF_FFFF, 4'h0, 0, 0, 0);
        check("zero_strb", reg_out[159:128], 32'h1234_5678);

        // Read of reg 2 on the same edge its write commits
        do_write(BASE + 32'h8, 32'h1, 4'hF, 0, 0, 0);
        awaddr = BASE + 32'h8; wdata = 32'h2; wstrb = 4'hF;
        awvalid = 1; wvalid = 1;
        check("coll_ready", {awready, wready, arready}, 3'b111);
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0;
        araddr = BASE + 32'h8; arvalid = 1;
        @(posedge clk); #1;
        arvalid = 0;
        check("coll_bvalid", bvalid, 1);
        check("coll_rvalid", rvalid, 1);
        check("coll_rdata", rdata, 32'h1);
        model[2] = 32'h2;
        check("coll_reg_out", reg_out, model_vec());
        bready = 1; rready = 1;
        @(posedge clk); #1;
        bready = 0; rready = 0;
        check("coll_clr", {bvalid, rvalid}, 2'b00);
        do_read(BASE + 32'h8, 0);

        // Randomised traffic, including misaligned low bits and out-of-range indices
        for (int n = 0; n < 40; n++) begin
            a = (BASE + (32'($urandom_range(0, NR + 1)) << 2)) | 32'($urandom_range(0, 3));
            do_write(a, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 2));
            a = (BASE + (32'($urandom_range(0, NR + 1)) << 2)) | 32'($urandom_range(0, 3));
            do_read(a, $urandom_range(0, 2));
        end

        // Asynchronous reset while B and R responses are pending
        send_aw_w(BASE + 32'h14, 32'hCAFE_F00D, 4'hF, 0, 0);
        @(posedge clk); #1;
        araddr = BASE + 32'h4; arvalid = 1;
        @(posedge clk); #1;
        arvalid = 0;
        check("pre_rst_pending", {bvalid, rvalid}, 2'b11);
        #2 rst = 1;
        #1;
        check("async_bvalid", bvalid, 0);
        check("async_rvalid", rvalid, 0);
        check("async_reg_out", reg_out, 0);
        check("async_readies", {awready, wready, arready}, 3'b000);
        clear_model();
        #2 rst = 0;
        @(posedge clk); #1;
        check("rerelease_readies", {awready, wready, arready}, 3'b111);
        check("rerelease_bvalid", bvalid, 0);
        do_read(BASE + 32'h4, 0);
        do_write(BASE + 32'h1C, 32'h0BAD_F00D, 4'hF, 0, 2, 1);
        do_read(BASE + 32'h1C, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
